home_cell_reader: RTL

- Upstream feeder for the reference-particle extraction stage.
- Sweeps the home-cell position RAM repeatedly, once per reference particle.
- Presents particle_id and home_pos_x/y/z one particle per cycle, with phase and prev_phase markers that delimit sweeps.
- Sits between the home-cell position memory and the ref-data extractor / filter pipeline.

---
 rtl/home_cell_reader.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/home_cell_reader.sv
// Sweeps the home-cell position RAM N times (one sweep per reference particle), one particle per cycle.
// Output beat follows its read by 1 cycle; stall gates new reads only, so one in-flight beat still lands.
module home_cell_reader #(
  parameter int DATA_WIDTH        = 32,
  parameter int PARTICLE_ID_WIDTH = 7
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         start_i,
  input  logic [PARTICLE_ID_WIDTH-1:0] particle_count_i,
  input  logic                         stall_i,
  output logic                         rd_en_o,
  output logic [PARTICLE_ID_WIDTH-1:0] rd_addr_o,
  input  logic [DATA_WIDTH-1:0]        rd_data_x_i,
  input  logic [DATA_WIDTH-1:0]        rd_data_y_i,
  input  logic [DATA_WIDTH-1:0]        rd_data_z_i,
  output logic [PARTICLE_ID_WIDTH-1:0] particle_id_o,
  output logic [DATA_WIDTH-1:0]        home_pos_x_o,
  output logic [DATA_WIDTH-1:0]        home_pos_y_o,
  output logic [DATA_WIDTH-1:0]        home_pos_z_o,
  output logic                         valid_o,
  output logic                         phase_o,
  output logic                         prev_phase_o,
  output logic                         busy_o,
  output logic                         done_o
);

  localparam int PW = PARTICLE_ID_WIDTH;
  localparam logic [PW-1:0] ID_ONE = PW'(1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   n_q, n_d;
  logic [PW-1:0]   id_cnt_q, id_cnt_d;
  logic [PW-1:0]   sweep_cnt_q, sweep_cnt_d;
  logic            phase_q, phase_d;
  logic            busy_q, busy_d;
  logic            prev_phase_q;
  logic            arm_q;
  logic            valid_q;
  logic [PW-1:0]   pid_q;
  logic [DATA_WIDTH-1:0] hold_x_q, hold_y_q, hold_z_q;
  logic            rd_en;

  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    id_cnt_d    = id_cnt_q;
    sweep_cnt_d = sweep_cnt_q;
    phase_d     = phase_q;
    busy_d      = busy_q;
    rd_en       = 1'b0;
    case (state_q)
      IDLE: begin
        // arm_q masks a start that arrives on the first edge after reset release
        if (start_i && arm_q) begin
          n_d     = particle_count_i;
          phase_d = 1'b0;
          if (particle_count_i == '0) begin
            state_d = FIN;
          end else begin
            id_cnt_d    = ID_ONE;
            sweep_cnt_d = ID_ONE;
            busy_d      = 1'b1;
            state_d     = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (!stall_i) begin
          rd_en = 1'b1;
          if (id_cnt_q == ID_ONE && sweep_cnt_q != ID_ONE) phase_d = ~phase_q;
          if (id_cnt_q < n_q) begin
            id_cnt_d = id_cnt_q + ID_ONE;
          end else if (sweep_cnt_q < n_q) begin
            id_cnt_d    = ID_ONE;
            sweep_cnt_d = sweep_cnt_q + ID_ONE;
          end else begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: state_d = FIN;
      FIN: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= IDLE;
      n_q          <= '0;
      id_cnt_q     <= '0;
      sweep_cnt_q  <= '0;
      phase_q      <= 1'b0;
      busy_q       <= 1'b0;
      prev_phase_q <= 1'b0;
      arm_q        <= 1'b0;
      valid_q      <= 1'b0;
      pid_q        <= '0;
      hold_x_q     <= '0;
      hold_y_q     <= '0;
      hold_z_q     <= '0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      id_cnt_q     <= id_cnt_d;
      sweep_cnt_q  <= sweep_cnt_d;
      phase_q      <= phase_d;
      busy_q       <= busy_d;
      prev_phase_q <= phase_q;
      arm_q        <= 1'b1;
      valid_q      <= rd_en;
      if (rd_en) pid_q <= id_cnt_q;
      // Keep our own copy so outputs clear on reset and hold regardless of RAM contents
      if (valid_q) begin
        hold_x_q <= rd_data_x_i;
        hold_y_q <= rd_data_y_i;
        hold_z_q <= rd_data_z_i;
      end
    end
  end

  assign rd_en_o       = rd_en;
  assign rd_addr_o     = rd_en ? (id_cnt_q - ID_ONE) : '0;
  assign particle_id_o = pid_q;
  assign valid_o       = valid_q;
  assign home_pos_x_o  = valid_q ? rd_data_x_i : hold_x_q;
  assign home_pos_y_o  = valid_q ? rd_data_y_i : hold_y_q;
  assign home_pos_z_o  = valid_q ? rd_data_z_i : hold_z_q;
  assign phase_o       = phase_q;
  assign prev_phase_o  = prev_phase_q;
  assign busy_o        = busy_q;
  assign done_o        = (state_q == FIN);

endmodule
